uart_core: RTL and testbench

Full-duplex 8N1 UART with a runtime-programmable bit period, a one-cycle valid/busy transmit handshake, a receive strobe, and optional echo of received bytes. It serves as the serial front end of the VGA terminal (`vgaminikbd`, UART0) and as the bench-side byte driver that feeds it. It contains no FIFO, so upstream logic paces transmission on `dataInTxBusy`.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_if.sv | 25 ++
 rtl/uart_rx_core.sv | 119 +++++++++++
 rtl/uart_core.sv | 142 ++++++++++++++
 tb/tb_uart_core.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: frame constants, FSM state types
// and the divider clamp used by both halves.
package uart_pkg;

  localparam int          DATA_BITS = 8;
  localparam logic [19:0] DIV_MIN   = 20'd4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Bit periods shorter than DIV_MIN cycles leave no room for the
  // half-bit start check, so they are raised to DIV_MIN.
  function automatic logic [19:0] clamp_div(input logic [19:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Byte-level handshake bundle between the UART and its user.
//
// Handshake: a transmit request is accepted on a rising edge where
// dataInTxValid=1 and dataInTxBusy=0; dataInTx is sampled on that edge and
// busy is visible high right after it. A request while busy is dropped, not
// queued. dataOutRxAvailable and rxError are one-cycle strobes with no
// back-pressure; dataOutRx holds the last good byte between strobes.
interface uart_if;
  logic [7:0] dataInTx;
  logic       dataInTxValid;
  logic       dataInTxBusy;
  logic [7:0] dataOutRx;
  logic       dataOutRxAvailable;
  logic       rxError;

  modport master (
    output dataInTx, dataInTxValid,
    input  dataInTxBusy, dataOutRx, dataOutRxAvailable, rxError
  );

  modport slave (
    input  dataInTx, dataInTxValid,
    output dataInTxBusy, dataOutRx, dataOutRxAvailable, rxError
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, falling-edge start detect with
// half-bit glitch rejection, then 8 data samples and a stop sample spaced
// one bit period apart. Reset is synchronous and active-high on rstn.
module uart_rx_core
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_i,
  input  logic [19:0] div_i,
  output logic [7:0]  data_o,
  output logic        avail_o,
  output logic        err_o,
  output logic        tick_o,
  output rx_state_t   state_o
);

  logic        sync1_q, sync2_q, prev_q;
  rx_state_t   state_q;
  logic [19:0] cnt_q;
  logic [19:0] div_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        avail_q, err_q, tick_q;
  logic [19:0] div_eff;

  assign div_eff = clamp_div(div_i);

  // Synchronize the line; resets high so releasing reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receive FSM; the start wait is shortened by one so the stop sample lands
  // 2 + D/2 + 9*D cycles after the line falls, counting synchronizer latency.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_MIN;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      avail_q <= 1'b0;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      avail_q <= 1'b0;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync2_q) begin
            div_q   <= div_eff;
            cnt_q   <= (div_eff >> 1) - 20'd2;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 20'd1;
          end else if (!sync2_q) begin
            tick_q  <= 1'b1;
            cnt_q   <= div_q - 20'd1;
            bit_q   <= '0;
            state_q <= RX_DATA;
          end else begin
            state_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 20'd1;
          end else begin
            tick_q  <= 1'b1;
            shift_q <= {sync2_q, shift_q[7:1]};
            cnt_q   <= div_q - 20'd1;
            if (bit_q == 3'(DATA_BITS - 1)) begin
              state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 20'd1;
          end else begin
            tick_q  <= 1'b1;
            state_q <= RX_IDLE;
            if (sync2_q) begin
              data_q  <= shift_q;
              avail_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign data_o  = data_q;
  assign avail_o = avail_q;
  assign err_o   = err_q;
  assign tick_o  = tick_q;
  assign state_o = state_q;

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART top: transmit FSM, echo arbitration and the receiver
// sub-module. Reset is synchronous and active-high on rstn.
module uart_core
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        ECHO,
  input  logic        UART_RX,
  output logic        UART_TX,
  input  logic [19:0] clockDividerValue,
  uart_if.slave       bus,
  output logic        rxBitTick,
  output logic        txBitTick,
  output tx_state_t   tx_state_o,
  output rx_state_t   rx_state_o
);

  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        rx_err;

  tx_state_t   tx_state_q;
  logic        tx_q;
  logic        busy_q;
  logic        tick_q;
  logic [19:0] cnt_q;
  logic [19:0] div_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_q;
  logic        echo_pend_q;
  logic [7:0]  echo_data_q;

  logic        echo_new;
  logic        echo_req;
  logic [7:0]  echo_byte;
  logic [19:0] div_eff;

  uart_rx_core u_rx (
    .clk     (clk),
    .rstn    (rstn),
    .rx_i    (UART_RX),
    .div_i   (clockDividerValue),
    .data_o  (rx_data),
    .avail_o (rx_avail),
    .err_o   (rx_err),
    .tick_o  (rxBitTick),
    .state_o (rx_state_o)
  );

  assign div_eff = clamp_div(clockDividerValue);

  // Echo source: a byte arriving this cycle beats (and replaces) an older pending one.
  always_comb begin
    echo_new  = ECHO && rx_avail;
    echo_req  = echo_pend_q || echo_new;
    echo_byte = echo_data_q;
    if (echo_new) echo_byte = rx_data;
  end

  // Transmit FSM with echo arbitration; an external request always wins over echo.
  always_ff @(posedge clk) begin
    if (rstn) begin
      tx_state_q  <= TX_IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      tick_q      <= 1'b0;
      cnt_q       <= '0;
      div_q       <= DIV_MIN;
      shift_q     <= '0;
      bit_q       <= '0;
      echo_pend_q <= 1'b0;
      echo_data_q <= '0;
    end else begin
      tick_q <= 1'b0;
      if (echo_new) begin
        echo_pend_q <= 1'b1;
        echo_data_q <= rx_data;
      end
      case (tx_state_q)
        TX_IDLE: begin
          if (bus.dataInTxValid || echo_req) begin
            shift_q     <= bus.dataInTxValid ? bus.dataInTx : echo_byte;
            div_q       <= div_eff;
            cnt_q       <= div_eff - 20'd1;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
            tx_state_q  <= TX_START;
            echo_pend_q <= 1'b0;
          end
        end
        TX_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 20'd1;
          end else begin
            tick_q     <= 1'b1;
            tx_q       <= shift_q[0];
            shift_q    <= shift_q >> 1;
            bit_q      <= '0;
            cnt_q      <= div_q - 20'd1;
            tx_state_q <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 20'd1;
          end else begin
            tick_q <= 1'b1;
            cnt_q  <= div_q - 20'd1;
            if (bit_q == 3'(DATA_BITS - 1)) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 20'd1;
          end else begin
            tick_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_state_q <= TX_IDLE;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign UART_TX                = tx_q;
  assign txBitTick              = tick_q;
  assign tx_state_o             = tx_state_q;
  assign bus.dataInTxBusy       = busy_q;
  assign bus.dataOutRx          = rx_data;
  assign bus.dataOutRxAvailable = rx_avail;
  assign bus.rxError            = rx_err;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: directed scenarios plus randomized frames; a line
// decoder and a strobe monitor check against expected queues.
`timescale 1ns/1ps
module tb_uart_core;
  import uart_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        echo = 1'b0;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic [19:0] div = 20'd131;
  wire         uart_rx;
  wire         uart_tx;
  wire         rx_tick;
  wire         tx_tick;
  tx_state_t   tx_st;
  rx_state_t   rx_st;

  uart_if bus_if();

  always #5 clk = ~clk;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  uart_core dut (
    .clk               (clk),
    .rstn              (rstn),
    .ECHO              (echo),
    .UART_RX           (uart_rx),
    .UART_TX           (uart_tx),
    .clockDividerValue (div),
    .bus               (bus_if),
    .rxBitTick         (rx_tick),
    .txBitTick         (tx_tick),
    .tx_state_o        (tx_st),
    .rx_state_o        (rx_st)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] tx_exp_q[$];
  logic [8:0] rx_exp_q[$];   // {is_error, dataOutRx expected at the strobe}
  int n_checks = 0;
  int n_pass   = 0;
  int n_avail  = 0;
  int n_err    = 0;
  int n_txtick = 0;
  int n_rxtick = 0;
  int tb_d     = 131;        // effective bit period of the frame on the line
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_tx(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (bus_if.dataInTxBusy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      $display("FAIL send_tx_wait: busy still high after %0d cycles, expected low", n);
    end
    bus_if.dataInTx      = b;
    bus_if.dataInTxValid = 1'b1;
    @(negedge clk);
    bus_if.dataInTxValid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (bus_if.dataInTxBusy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) begin
      n_checks++;
      $display("FAIL %s: busy still high after %0d cycles, expected low", name, bound);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    rx_drv = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (d) @(negedge clk);
    end
    rx_drv = stop;
    repeat (d) @(negedge clk);
    rx_drv = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  // Receive strobes: compare each event against the next expected one.
  always @(negedge clk) begin
    if (!rstn) begin
      if (tx_tick) n_txtick++;
      if (rx_tick) n_rxtick++;
      if (bus_if.dataOutRxAvailable || bus_if.rxError) begin
        if (bus_if.dataOutRxAvailable) n_avail++;
        if (bus_if.rxError) n_err++;
        check("rx_strobe_exclusive", 32'(bus_if.dataOutRxAvailable & bus_if.rxError), 32'd0);
        if (rx_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected: got err=%0b byte=%02h, expected no event",
                   bus_if.rxError, bus_if.dataOutRx);
        end else begin
          check("rx_event", 32'({bus_if.rxError, bus_if.dataOutRx}), 32'(rx_exp_q.pop_front()));
        end
      end
    end
  end

  // Serial line decoder: samples UART_TX mid-bit using the bench's bit period.
  logic       mon_act = 1'b0;
  logic       mon_prev = 1'b1;
  logic       mon_start = 1'b0;
  logic [7:0] mon_sh = 8'h00;
  int         mon_cnt = 0;
  int         mon_bit = 0;
  always @(negedge clk) begin
    if (rstn) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (mon_prev && !uart_tx) begin
        mon_act = 1'b1;
        mon_cnt = tb_d / 2;
        mon_bit = 0;
      end
    end else begin
      mon_cnt--;
      if (mon_cnt == 0) begin
        if (mon_bit == 0) begin
          mon_start = uart_tx;
        end else if (mon_bit <= 8) begin
          mon_sh[mon_bit-1] = uart_tx;
        end else begin
          check("tx_framing", 32'({mon_start, uart_tx}), 32'd1);
          if (tx_exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected: got frame %02h, expected no frame", mon_sh);
          end else begin
            check("tx_byte", 32'(mon_sh), 32'(tx_exp_q.pop_front()));
          end
          mon_act = 1'b0;
        end
        mon_bit++;
        mon_cnt = tb_d;
      end
    end
    mon_prev = uart_tx;
  end

  // Echo launch: one cycle after the available strobe the line must be in
  // its start bit (ECHO=1) or still idle (ECHO=0).
  logic avail_prev = 1'b0;
  logic echo_watch = 1'b0;
  always @(negedge clk) begin
    if (echo_watch && avail_prev)
      check("echo_start", 32'({uart_tx, bus_if.dataInTxBusy}), echo ? 32'd1 : 32'd2);
    avail_prev = bus_if.dataOutRxAvailable;
  end

  // Watchdog
  initial begin
    #2_000_000;
    n_checks++;
    $display("FAIL watchdog: simulation still running at 2 ms, expected done");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0, r0, e0, a0, n;
    int d, div_raw, mode;
    logic [7:0] b;

    bus_if.dataInTx      = 8'h00;
    bus_if.dataInTxValid = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;

    // Reset values
    check("reset_outputs",
          32'({uart_tx, bus_if.dataInTxBusy, bus_if.dataOutRxAvailable, bus_if.rxError,
               rx_tick, tx_tick, bus_if.dataOutRx}),
          32'({1'b1, 5'b0, 8'h00}));
    check("reset_states", 32'({tx_st, rx_st}), 32'({TX_IDLE, RX_IDLE}));

    // TX 'a' at D=131: busy duration and tick count
    tb_d = 131; div = 20'd131;
    tx_exp_q.push_back(8'h61);
    t0 = n_txtick;
    send_tx(8'h61);
    n = 0;
    while (bus_if.dataInTxBusy && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'd1310);
    repeat (3) @(negedge clk);
    check("tx_ticks", 32'(n_txtick - t0), 32'd10);

    // Loopback 0x61 then 0x08 back-to-back
    loop_en = 1'b1;
    r0 = n_rxtick; e0 = n_err;
    tx_exp_q.push_back(8'h61); rx_exp_q.push_back({1'b0, 8'h61});
    tx_exp_q.push_back(8'h08); rx_exp_q.push_back({1'b0, 8'h08});
    send_tx(8'h61);
    send_tx(8'h08);
    wait_idle("loop_idle", 3000);
    repeat (2 * 131 + 10) @(negedge clk);
    loop_en = 1'b0;
    last_good = 8'h08;
    check("loop_rx_ticks", 32'(n_rxtick - r0), 32'd20);
    check("loop_no_error", 32'(n_err - e0), 32'd0);

    // Framing error on 0xA5
    rx_exp_q.push_back({1'b1, last_good});
    send_rx(8'hA5, 1'b0, 131);
    repeat (20) @(negedge clk);
    check("frame_err_keeps_data", 32'(bus_if.dataOutRx), 32'(last_good));

    // Glitch of 20 cycles
    a0 = n_avail; e0 = n_err; r0 = n_rxtick;
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_rx_idle", 32'(rx_st), 32'(RX_IDLE));
    check("glitch_no_strobes", 32'((n_avail - a0) + (n_err - e0) + (n_rxtick - r0)), 32'd0);

    // Echo on
    echo = 1'b1; echo_watch = 1'b1;
    rx_exp_q.push_back({1'b0, 8'h55});
    tx_exp_q.push_back(8'h55);
    send_rx(8'h55, 1'b1, 131);
    wait_idle("echo_idle", 3000);
    repeat (10) @(negedge clk);
    last_good = 8'h55;

    // Echo off: no retransmission
    echo = 1'b0;
    rx_exp_q.push_back({1'b0, 8'h5A});
    send_rx(8'h5A, 1'b1, 131);
    repeat (300) @(negedge clk);
    echo_watch = 1'b0;
    last_good = 8'h5A;
    check("echo_off_idle", 32'(bus_if.dataInTxBusy), 32'd0);

    // Request while busy is dropped
    tx_exp_q.push_back(8'hC3);
    send_tx(8'hC3);
    repeat (3 * 131) @(negedge clk);
    bus_if.dataInTx = 8'h33; bus_if.dataInTxValid = 1'b1;
    @(negedge clk);
    bus_if.dataInTxValid = 1'b0;
    wait_idle("busy_drop_idle", 3000);
    repeat (300) @(negedge clk);
    check("no_second_frame", 32'(bus_if.dataInTxBusy), 32'd0);

    // Reset mid-frame
    send_tx(8'h9E);
    repeat (4 * 131) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("reset_mid_frame", 32'({uart_tx, bus_if.dataInTxBusy}), 32'd2);
    check("reset_mid_state", 32'(tx_st), 32'(TX_IDLE));
    @(negedge clk);
    rstn = 1'b0;
    last_good = 8'h00;
    check("reset_clears_rx_data", 32'(bus_if.dataOutRx), 32'd0);

    // Randomized frames with random dividers (values below 4 behave as 4)
    for (int it = 0; it < 14; it++) begin
      div_raw = $urandom_range(0, 24);
      d = (div_raw < 4) ? 4 : div_raw;
      div = 20'(div_raw);
      tb_d = d;
      b = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        loop_en = 1'b1;
        tx_exp_q.push_back(b);
        rx_exp_q.push_back({1'b0, b});
        last_good = b;
        send_tx(b);
        wait_idle("rand_loop_idle", 1000);
        repeat (2 * d + 8) @(negedge clk);
        loop_en = 1'b0;
      end else if (mode == 1) begin
        rx_exp_q.push_back({1'b0, b});
        last_good = b;
        send_rx(b, 1'b1, d);
      end else begin
        rx_exp_q.push_back({1'b1, last_good});
        send_rx(b, 1'b0, d);
      end
      repeat (8) @(negedge clk);
    end

    repeat (50) @(negedge clk);
    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
